// File: rtl/mem_copy_engine.sv
// Block-copy engine: copies Length entries from SrcAddr to DstAddr through a
// single-port memory, alternating one read and one write per entry.
module mem_copy_engine #(
   parameter int unsigned W = 8,
   parameter int unsigned A = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [A-1:0] SrcAddr,
   input  logic [A-1:0] DstAddr,
   input  logic [A:0]   Length,
   output logic         Busy,
   output logic         Done,
   output logic [A-1:0] MemAddress,
   output logic         MemWriteEn,
   output logic [W-1:0] MemWrData,
   input  logic [W-1:0] MemRdData
);

   localparam int unsigned LW = A + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      WRITE  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t          state, state_next;
   logic [A-1:0]    src, src_next;
   logic [A-1:0]    dst, dst_next;
   logic [LW-1:0]   len, len_next;
   logic [LW-1:0]   idx, idx_next;
   logic [W-1:0]    buffer, buffer_next;
   logic            busy_next, done_next, wren_next;
   logic [A-1:0]    addr_next;
   logic [W-1:0]    wrdata_next;

   // Next-state, datapath and next-output decode; bus outputs follow the next state
   always_comb begin
      state_next  = state;
      src_next    = src;
      dst_next    = dst;
      len_next    = len;
      idx_next    = idx;
      buffer_next = buffer;
      busy_next   = 1'b0;
      done_next   = 1'b0;
      wren_next   = 1'b0;
      addr_next   = MemAddress;
      wrdata_next = MemWrData;

      unique case (state)
         IDLE: begin
            if (Start) begin
               src_next   = SrcAddr;
               dst_next   = DstAddr;
               len_next   = Length;
               idx_next   = '0;
               state_next = (Length == '0) ? FINISH : READ;
            end
         end
         READ: begin
            buffer_next = MemRdData;
            state_next  = WRITE;
         end
         WRITE: begin
            idx_next   = idx + LW'(1);
            state_next = ((idx + LW'(1)) == len) ? FINISH : READ;
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      unique case (state_next)
         READ: begin
            busy_next = 1'b1;
            addr_next = src_next + idx_next[A-1:0];
         end
         WRITE: begin
            busy_next   = 1'b1;
            wren_next   = 1'b1;
            addr_next   = dst_next + idx_next[A-1:0];
            wrdata_next = buffer_next;
         end
         FINISH:  done_next = 1'b1;
         default: ;
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         src        <= '0;
         dst        <= '0;
         len        <= '0;
         idx        <= '0;
         buffer     <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         MemWriteEn <= 1'b0;
         MemAddress <= '0;
         MemWrData  <= '0;
      end else begin
         state      <= state_next;
         src        <= src_next;
         dst        <= dst_next;
         len        <= len_next;
         idx        <= idx_next;
         buffer     <= buffer_next;
         Busy       <= busy_next;
         Done       <= done_next;
         MemWriteEn <= wren_next;
         MemAddress <= addr_next;
         MemWrData  <= wrdata_next;
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: memory model plus reference copy model.
module tb_mem_copy_engine;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic [7:0] SrcAddr, DstAddr;
   logic [8:0] Length;
   logic       Busy, Done;
   logic [7:0] MemAddress;
   logic       MemWriteEn;
   logic [7:0] MemWrData;
   logic [7:0] MemRdData;

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   logic       tb_we;
   logic [7:0] tb_wa, tb_wd;

   int checks = 0;
   int errors = 0;

   mem_copy_engine #(.W(8), .A(8)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start),
      .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
      .Busy(Busy), .Done(Done),
      .MemAddress(MemAddress), .MemWriteEn(MemWriteEn),
      .MemWrData(MemWrData), .MemRdData(MemRdData)
   );

   always #5 Clk = ~Clk;

   // Single-port memory: combinational read, write on posedge
   assign MemRdData = mem[MemAddress];
   always @(posedge Clk) begin
      if (MemWriteEn) mem[MemAddress] <= MemWrData;
      else if (tb_we) mem[tb_wa] <= tb_wd;
   end

   typedef struct {
      string      name;
      logic [7:0] src;
      logic [7:0] dst;
      int         len;
      int         poke;
      int         exp_lat;
      int         exp_wr;
      int         nd;
      logic [7:0] d [4];
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      tb_wa = a; tb_wd = v; tb_we = 1'b1; ref_mem[a] = v;
      @(negedge Clk);
      tb_we = 1'b0;
   endtask

   // Copy semantics: strictly ascending, each entry read then written
   task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
      for (int k = 0; k < n; k++) ref_mem[8'(d + k)] = ref_mem[8'(s + k)];
   endtask

   function automatic int mem_diffs();
      int m = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) m++;
      return m;
   endfunction

   task automatic run_case(input string name, input logic [7:0] s, input logic [7:0] d,
                           input int n, input int poke, input int exp_lat, input int exp_wr);
      int lat, wr, busy_bad, rd_bad, wr_bad, nrd;
      logic [7:0] rq [$];
      logic [7:0] wq [$];
      @(negedge Clk);
      SrcAddr = s; DstAddr = d; Length = 9'(n); Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0; SrcAddr = 8'h00; DstAddr = 8'h00; Length = 9'd0;
      lat = 1; wr = 0; busy_bad = 0;
      while (!Done && lat < 700) begin
         if (!Busy) busy_bad++;
         if (MemWriteEn) begin wr++; wq.push_back(MemAddress); end
         else rq.push_back(MemAddress);
         if (poke != 0 && lat == poke) begin
            SrcAddr = 8'h90; DstAddr = 8'hA0; Length = 9'd2; Start = 1'b1;
         end
         if (poke != 0 && lat == poke + 1) Start = 1'b0;
         @(negedge Clk);
         lat++;
      end
      Start = 1'b0;
      chk({name, "_done_lat"}, lat, exp_lat);
      chk({name, "_writes"}, wr, exp_wr);
      chk({name, "_busy_in_copy"}, busy_bad, 0);
      chk({name, "_busy_at_done"}, 32'(Busy), 0);
      chk({name, "_we_at_done"}, 32'(MemWriteEn), 0);
      rd_bad = 0; wr_bad = 0; nrd = rq.size();
      for (int k = 0; k < wq.size(); k++) if (wq[k] != 8'(d + k)) wr_bad++;
      for (int k = 0; k < nrd; k++) if (rq[k] != 8'(s + k)) rd_bad++;
      chk({name, "_wr_addr"}, wr_bad, 0);
      chk({name, "_rd_addr"}, rd_bad + (nrd == n ? 0 : 1000), 0);
      @(negedge Clk);
      chk({name, "_done_single"}, 32'(Done) + 32'(Busy), 0);
      model_copy(s, d, n);
      chk({name, "_mem"}, mem_diffs(), 0);
   endtask

   initial begin
      int lat_err;
      Reset = 1'b1; Start = 1'b0; SrcAddr = 8'h00; DstAddr = 8'h00; Length = 9'd0;
      tb_we = 1'b0; tb_wa = 8'h00; tb_wd = 8'h00;

      tbl[0] = '{"basic",   8'h10, 8'h40, 4,   0, 9,   4,   4, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}};
      tbl[1] = '{"zero",    8'h05, 8'h06, 0,   0, 1,   0,   0, '{8'h00, 8'h00, 8'h00, 8'h00}};
      tbl[2] = '{"wrap",    8'hFE, 8'h80, 3,   0, 7,   3,   3, '{8'h11, 8'h22, 8'h33, 8'h00}};
      tbl[3] = '{"overlap", 8'h20, 8'h21, 2,   0, 5,   2,   2, '{8'h5A, 8'h5A, 8'h00, 8'h00}};
      tbl[4] = '{"restart", 8'h30, 8'h70, 4,   3, 9,   4,   0, '{8'h00, 8'h00, 8'h00, 8'h00}};
      tbl[5] = '{"full",    8'h00, 8'h00, 256, 0, 513, 256, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
      tbl[6] = '{"same",    8'h44, 8'h44, 3,   0, 7,   3,   0, '{8'h00, 8'h00, 8'h00, 8'h00}};

      #12;
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_done", 32'(Done), 0);
      chk("rst_we", 32'(MemWriteEn), 0);
      chk("rst_addr", 32'(MemAddress), 0);
      chk("rst_wdata", 32'(MemWrData), 0);

      @(negedge Clk);
      for (int a = 0; a < 256; a++) preload(8'(a), 8'($urandom_range(0, 255)));
      preload(8'h10, 8'hAA); preload(8'h11, 8'hBB); preload(8'h12, 8'hCC); preload(8'h13, 8'hDD);
      preload(8'hFE, 8'h11); preload(8'hFF, 8'h22); preload(8'h00, 8'h33);
      preload(8'h20, 8'h5A); preload(8'h21, 8'h00);
      Reset = 1'b0;
      @(negedge Clk);

      for (int t = 0; t < 7; t++) begin
         run_case(tbl[t].name, tbl[t].src, tbl[t].dst, tbl[t].len, tbl[t].poke,
                  tbl[t].exp_lat, tbl[t].exp_wr);
         for (int k = 0; k < tbl[t].nd; k++)
            chk({tbl[t].name, "_data"}, 32'(mem[8'(tbl[t].dst + k)]), 32'(tbl[t].d[k]));
      end

      for (int r = 0; r < 16; r++) begin
         logic [7:0] s, d;
         int n;
         s = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         n = $urandom_range(0, 12);
         run_case("rand", s, d, n, 0, 2 * n + 1, n);
      end

      // Asynchronous reset during the second write of a 4-entry copy
      preload(8'h50, 8'h01); preload(8'h51, 8'h02); preload(8'h52, 8'h03); preload(8'h53, 8'h04);
      preload(8'h60, 8'hF0); preload(8'h61, 8'hF1); preload(8'h62, 8'hF2); preload(8'h63, 8'hF3);
      SrcAddr = 8'h50; DstAddr = 8'h60; Length = 9'd4; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rstmid_in_write", 32'(MemWriteEn), 1);
      #2 Reset = 1'b1;
      #1;
      chk("rstmid_we_drop", 32'(MemWriteEn), 0);
      chk("rstmid_busy_drop", 32'(Busy), 0);
      lat_err = 0;
      repeat (3) begin @(negedge Clk); if (Done || MemWriteEn || Busy) lat_err++; end
      Reset = 1'b0;
      repeat (2) begin @(negedge Clk); if (Done || MemWriteEn || Busy) lat_err++; end
      chk("rstmid_quiet", lat_err, 0);
      chk("rstmid_first", 32'(mem[8'h60]), 32'h01);
      chk("rstmid_second", 32'((mem[8'h61] == 8'h02) || (mem[8'h61] == 8'hF1)), 1);
      chk("rstmid_third", 32'(mem[8'h62]), 32'hF2);
      chk("rstmid_fourth", 32'(mem[8'h63]), 32'hF3);
      ref_mem[8'h60] = 8'h01;
      if (mem[8'h61] == 8'h02) ref_mem[8'h61] = 8'h02;
      run_case("after_rst", 8'h52, 8'hC0, 1, 0, 3, 1);
      chk("after_rst_data", 32'(mem[8'hC0]), 32'h03);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side block-copy engine that drives the single-port data memory's address/write-enable/write-data pins and consumes its combinational read data.
- Copies Length consecutive entries from SrcAddr to DstAddr, one memory access per cycle: alternating read and write.
- Sits beside the core as a memory-bus master.
- Start/Busy/Done handshake toward the issuing controller.

Parameters:
W, 8, data width of one memory entry (matches memory W)
A, 8, address width; memory depth 2**A (matches memory A)

Ports:
Clk  input  1  system clock, all state updates on posedge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request a copy; sampled only in IDLE
SrcAddr  input  A  first source address; latched on accepted Start
DstAddr  input  A  first destination address; latched on accepted Start
Length  input  A+1  entry count, 0..2**A; latched on accepted Start
Busy  output  1  high from the cycle after Start is accepted until Done is asserted
Done  output  1  one-cycle completion pulse
MemAddress  output  A  to memory DataAddress
MemWriteEn  output  1  to memory WriteEn
MemWrData  output  W  to memory DataIn
MemRdData  input  W  from memory DataOut (combinational read of MemAddress)

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, Busy=0, Done=0, MemWriteEn=0, MemAddress=0, MemWrData=0. Internal src/dst/len/index/buffer registers are all 0.
- FSM states: IDLE, READ, WRITE, FINISH.
- IDLE:
  - Busy=0, MemWriteEn=0.
  - On Start=1 at a posedge, latch SrcAddr, DstAddr and Length, and clear index i to 0.
  - If Length==0, go to FINISH. Otherwise go to READ.
- READ:
  - MemAddress=src+i (mod 2**A), MemWriteEn=0.
  - At posedge, capture MemRdData into buffer and go to WRITE.
- WRITE:
  - MemAddress=dst+i (mod 2**A), MemWriteEn=1, MemWrData=buffer.
  - At posedge, i<=i+1.
  - If i+1==len, go to FINISH. Otherwise go to READ.
- FINISH:
  - Done=1 and Busy=0 for exactly this cycle.
  - Next state is IDLE.
- Output timing:
  - Busy=1 in READ and WRITE.
  - MemAddress, MemWriteEn and MemWrData are decoded from registered state only. They have no combinational path from Start or MemRdData.
- Latency: copy of N entries takes 2N cycles of Busy, then 1 Done cycle. Done is asserted 2N+1 cycles after the accepting edge (N=0: 1 cycle).
- Address arithmetic: A-bit, wraps modulo 2**A. Length=2**A copies every entry exactly once. Index i is A+1 bits.
- Overlap: copy is strictly ascending, read-then-write per entry.
  - dst>src with overlap replicates the leading pattern. This is defined behaviour, not an error.
  - dst==src rewrites identical data.
- Start while Busy or during FINISH is ignored; no queuing. Start must be re-asserted in IDLE.
- Input changes after acceptance have no effect on an in-flight copy, because src, dst and len are latched.
- Reset mid-operation:
  - Immediately forces IDLE and MemWriteEn=0.
  - No further writes occur.
  - Done is not pulsed.
  - Memory contents already written stay written.
- Idle bus: MemWriteEn=0 in IDLE and FINISH, so the memory is never written outside WRITE.

Test Plan:
- Basic copy: preload mem[0x10..0x13]=AA,BB,CC,DD; Start with Src=0x10, Dst=0x40, Len=4 -> mem[0x40..0x43]=AA,BB,CC,DD; Done pulses 9 cycles after acceptance; exactly 4 write cycles observed.
- Zero length: Len=0, Src=0x05, Dst=0x06 -> Done on the cycle after acceptance; MemWriteEn never 1; memory unchanged.
- Wrap-around: preload mem[0xFE]=11, mem[0xFF]=22, mem[0x00]=33; Src=0xFE, Dst=0x80, Len=3 -> mem[0x80..0x82]=11,22,33; write addresses 0x80,0x81,0x82; read addresses 0xFE,0xFF,0x00.
- Overlap forward: mem[0x20]=5A, mem[0x21]=00; Src=0x20, Dst=0x21, Len=2 -> mem[0x21]=5A, mem[0x22]=5A.
- Busy/Start interaction: issue Start again 3 cycles into a Len=4 copy with different Src/Dst -> ignored; only the original destination is written; single Done pulse.
- Async reset mid-copy: assert Reset between clock edges during the 2nd WRITE of a Len=4 copy -> MemWriteEn falls immediately; Busy=0; only the first 1-2 destination entries are written; no Done; after release a new Start with Len=1 completes normally with Done after 3 cycles.
